pid_terms_pipe: RTL and testbench

//  Parametrised successor of the single proportional-term block: computes saturated P, I and D terms

---
 rtl/pid_pkg.sv | 26 ++
 rtl/pid_sat.sv | 14 +
 rtl/pid_terms_pipe.sv | 113 +++++++++++
 tb/tb_pid_terms_pipe.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/pid_pkg.sv
// Shared defaults and the signed saturation helper for the PID term pipeline.
package pid_pkg;

  localparam int unsigned ERR_W_DEF   = 12;
  localparam int unsigned SAT_W_DEF   = 10;
  localparam logic [5:0]  P_COEFF_DEF = 6'h10;
  localparam int unsigned I_W_DEF     = 15;
  localparam int unsigned I_SHIFT_DEF = 6;
  localparam int unsigned D_DEPTH_DEF = 2;
  localparam int unsigned D_SAT_W_DEF = 7;
  localparam logic [4:0]  D_COEFF_DEF = 5'h07;
  localparam int unsigned OUT_W_DEF   = 14;

  // Clamp a sign-extended value into the signed range of out_w bits (out_w < 32).
  function automatic logic signed [31:0] sat_signed(input logic signed [31:0] v,
                                                   input int unsigned out_w);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (out_w - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (out_w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/pid_sat.sv
// Combinational signed saturator from IN_W bits down to OUT_W bits.
module pid_sat
  import pid_pkg::*;
#(
  parameter int unsigned IN_W  = 16,
  parameter int unsigned OUT_W = 14
) (
  input  logic [IN_W-1:0]  i_in,
  output logic [OUT_W-1:0] o_out
);

  assign o_out = OUT_W'(sat_signed(32'($signed(i_in)), OUT_W));

endmodule

// File: rtl/pid_terms_pipe.sv
// Two-stage PID term pipeline: saturated P, anti-windup I, history-based D and saturated sum.
module pid_terms_pipe
  import pid_pkg::*;
#(
  parameter int unsigned ERR_W   = ERR_W_DEF,
  parameter int unsigned SAT_W   = SAT_W_DEF,
  parameter logic [5:0]  P_COEFF = P_COEFF_DEF,
  parameter int unsigned I_W     = I_W_DEF,
  parameter int unsigned I_SHIFT = I_SHIFT_DEF,
  parameter int unsigned D_DEPTH = D_DEPTH_DEF,
  parameter int unsigned D_SAT_W = D_SAT_W_DEF,
  parameter logic [4:0]  D_COEFF = D_COEFF_DEF,
  parameter int unsigned OUT_W   = OUT_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [ERR_W-1:0]       error,
  input  logic                   err_vld,
  input  logic                   moving,
  output logic [SAT_W+3:0]       P_term,
  output logic [I_W-I_SHIFT-1:0] I_term,
  output logic [D_SAT_W+4:0]     D_term,
  output logic [OUT_W-1:0]       PID,
  output logic                   pid_vld
);

  localparam int unsigned P_W   = SAT_W + 4;
  localparam int unsigned PP_W  = SAT_W + 6;
  localparam int unsigned IT_W  = I_W - I_SHIFT;
  localparam int unsigned DF_W  = SAT_W + 1;
  localparam int unsigned D_W   = D_SAT_W + 5;
  localparam int unsigned SUM_W = OUT_W + 2;

  logic [SAT_W-1:0] w_err_sat;
  logic [SAT_W-1:0] r_err_s1;
  logic             r_vld_s1;

  pid_sat #(.IN_W(ERR_W), .OUT_W(SAT_W)) u_sat_err (.i_in(error), .o_out(w_err_sat));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_s1 <= '0;
      r_vld_s1 <= 1'b0;
    end else begin
      r_err_s1 <= w_err_sat;
      r_vld_s1 <= err_vld;
    end
  end

  logic [PP_W-1:0] w_p_prod;
  logic [P_W-1:0]  w_p_next;

  assign w_p_prod = PP_W'($signed(r_err_s1)) * PP_W'($signed(P_COEFF));

  pid_sat #(.IN_W(PP_W), .OUT_W(P_W)) u_sat_p (.i_in(w_p_prod), .o_out(w_p_next));

  logic [I_W-1:0]  r_integ;
  logic [I_W:0]    w_integ_sum;
  logic [I_W-1:0]  w_integ_clamp;
  logic [I_W-1:0]  w_integ_upd;
  logic [IT_W-1:0] w_i_next;

  assign w_integ_sum   = (I_W+1)'($signed(r_integ)) + (I_W+1)'($signed(r_err_s1));
  assign w_integ_clamp = I_W'(sat_signed(32'($signed(w_integ_sum)), I_W));
  // Not moving forces the term to see a cleared integrator in the same cycle.
  assign w_integ_upd   = moving ? w_integ_clamp : '0;
  assign w_i_next      = IT_W'($signed(w_integ_upd) >>> I_SHIFT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          r_integ <= '0;
    else if (!moving)    r_integ <= '0;
    else if (r_vld_s1)   r_integ <= w_integ_clamp;
  end

  logic [SAT_W-1:0]   r_hist [D_DEPTH];
  logic [DF_W-1:0]    w_diff;
  logic [D_SAT_W-1:0] w_diff_sat;
  logic [D_W-1:0]     w_d_next;

  assign w_diff   = DF_W'($signed(r_err_s1)) - DF_W'($signed(r_hist[D_DEPTH-1]));
  assign w_d_next = D_W'($signed(w_diff_sat)) * D_W'($signed(D_COEFF));

  pid_sat #(.IN_W(DF_W), .OUT_W(D_SAT_W)) u_sat_d (.i_in(w_diff), .o_out(w_diff_sat));

  logic [SUM_W-1:0] w_sum;
  logic [OUT_W-1:0] w_pid_next;

  assign w_sum = SUM_W'($signed(w_p_next)) + SUM_W'($signed(w_i_next)) + SUM_W'($signed(w_d_next));

  pid_sat #(.IN_W(SUM_W), .OUT_W(OUT_W)) u_sat_pid (.i_in(w_sum), .o_out(w_pid_next));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      P_term  <= '0;
      I_term  <= '0;
      D_term  <= '0;
      PID     <= '0;
      pid_vld <= 1'b0;
      for (int unsigned k = 0; k < D_DEPTH; k++) r_hist[k] <= '0;
    end else begin
      pid_vld <= r_vld_s1;
      if (r_vld_s1) begin
        P_term <= w_p_next;
        I_term <= w_i_next;
        D_term <= w_d_next;
        PID    <= w_pid_next;
        for (int unsigned k = D_DEPTH - 1; k > 0; k--) r_hist[k] <= r_hist[k-1];
        r_hist[0] <= r_err_s1;
      end
    end
  end

endmodule

// File: tb/tb_pid_terms_pipe.sv
// Scoreboard bench for pid_terms_pipe: issued samples push expected terms, a monitor pops on pid_vld.
module tb_pid_terms_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [11:0] error;
  logic        err_vld;
  logic        moving;
  logic [13:0] P_term;
  logic [8:0]  I_term;
  logic [11:0] D_term;
  logic [13:0] PID;
  logic        pid_vld;

  pid_terms_pipe dut (
    .clk(clk), .rst_n(rst_n), .error(error), .err_vld(err_vld), .moving(moving),
    .P_term(P_term), .I_term(I_term), .D_term(D_term), .PID(PID), .pid_vld(pid_vld)
  );

  always #5 clk = ~clk;

  typedef struct { int p; int i; int d; int pid; } exp_t;
  exp_t q[$];
  int total = 0;
  int bad = 0;
  int m_integ = 0;
  int m_h0 = 0;
  int m_h1 = 0;

  function automatic int sat(int v, int w);
    int hi;
    int lo;
    hi = (1 << (w - 1)) - 1;
    lo = -(1 << (w - 1));
    return (v > hi) ? hi : ((v < lo) ? lo : v);
  endfunction

  task automatic check(string name, int act, int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", name, act, req, $time);
    end
  endtask

  function automatic void model_push(logic [11:0] e, logic mv);
    exp_t x;
    int es;
    int diff;
    es = sat(int'($signed(e)), 10);
    x.p = sat(es * 16, 14);
    m_integ = mv ? sat(m_integ + es, 15) : 0;
    x.i = m_integ >>> 6;
    diff = sat(es - m_h1, 7);
    x.d = diff * 7;
    m_h1 = m_h0;
    m_h0 = es;
    x.pid = sat(x.p + x.i + x.d, 14);
    q.push_back(x);
  endfunction

  task automatic send(logic [11:0] e, bit push = 1'b1);
    @(posedge clk);
    #1;
    error   = e;
    err_vld = 1'b1;
    if (push) model_push(e, moving);
  endtask

  task automatic idle(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      err_vld = 1'b0;
    end
  endtask

  task automatic drain();
    idle(1);
    for (int k = 0; k < 20 && q.size() != 0; k++) @(negedge clk);
    if (q.size() != 0) check("drain_timeout", q.size(), 0);
    @(negedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1 && pid_vld === 1'b1) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_vld: got pid_vld 1 want no output at %0t", $time);
      end else begin
        exp_t x;
        x = q.pop_front();
        check("sb_P",   int'($signed(P_term)), x.p);
        check("sb_I",   int'($signed(I_term)), x.i);
        check("sb_D",   int'($signed(D_term)), x.d);
        check("sb_PID", int'($signed(PID)),    x.pid);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n   = 1'b0;
    error   = 12'h7FF;
    err_vld = 1'b1;
    moving  = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_P",   int'(P_term), 0);
    check("rst_I",   int'(I_term), 0);
    check("rst_D",   int'(D_term), 0);
    check("rst_PID", int'(PID), 0);
    check("rst_vld", int'(pid_vld), 0);
    @(posedge clk);
    #1;
    err_vld = 1'b0;
    rst_n   = 1'b1;
    repeat (3) @(negedge clk);
    check("post_rst_vld", int'(pid_vld), 0);
    check("post_rst_P",   int'(P_term), 0);

    send(12'h7FF);
    drain();
    check("p_max", int'($signed(P_term)), 8176);
    check("p_pulse_end", int'(pid_vld), 0);
    send(12'h800);
    drain();
    check("p_min", int'($signed(P_term)), -8192);
    send(12'd0);
    send(12'd0);
    drain();

    moving = 1'b1;
    repeat (10) send(12'd100);
    drain();
    check("i_acc", int'($signed(I_term)), 15);
    repeat (40) send(12'd511);
    drain();
    check("i_pin", int'($signed(I_term)), 255);
    send(12'd0);
    send(12'd0);
    send(12'd511);
    drain();
    check("sum_D",   int'($signed(D_term)), 441);
    check("sum_I",   int'($signed(I_term)), 255);
    check("sum_PID", int'($signed(PID)), 8191);
    repeat (3) begin
      @(negedge clk);
      check("gap_vld", int'(pid_vld), 0);
      check("gap_PID", int'($signed(PID)), 8191);
    end

    moving = 1'b0;
    send(12'd511);
    drain();
    check("i_clear", int'($signed(I_term)), 0);

    send(12'd0);
    send(12'd0);
    send(12'd50);
    drain();
    check("d_step1", int'($signed(D_term)), 350);
    send(12'd50);
    drain();
    check("d_step2", int'($signed(D_term)), 350);
    send(12'd50);
    drain();
    check("d_step3", int'($signed(D_term)), 0);
    send(12'd0);
    send(12'd0);
    send(12'd300);
    drain();
    check("d_sat", int'($signed(D_term)), 441);

    send(12'd200, 1'b0);
    @(posedge clk);
    #2;
    rst_n   = 1'b0;
    err_vld = 1'b0;
    m_integ = 0;
    m_h0    = 0;
    m_h1    = 0;
    @(negedge clk);
    check("midrst_vld", int'(pid_vld), 0);
    check("midrst_D",   int'(D_term), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("midrst_drop", int'(pid_vld), 0);
    send(12'd0);
    drain();
    check("midrst_hist", int'($signed(D_term)), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
